maxpool2x2_stream: RTL and testbench

// - Streaming 2x2 / stride-2 max-pool for the two conv feature-map channels. Replaces the current pass-through pool stage.
// - Consumes the raster-ordered conv/ReLU stream: 6x6 positions, one position per in_valid pulse, both channels in parallel.
// - Emits 3x3 pooled positions per channel, in raster order, to the linear stage.
// - No backpressure: every in_valid beat is accepted, and upstream never stalls.

---
 rtl/nn_pkg.sv | 22 ++
 rtl/maxpool2x2_stream_if.sv | 25 ++
 rtl/maxpool2x2_stream_pool_lane.sv | 43 ++++
 rtl/maxpool2x2_stream.sv | 104 ++++++++++
 tb/tb_maxpool2x2_stream.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Constants and helpers shared by the conv, pool and linear stages of the
// feature-map pipeline.
package nn_pkg;

    localparam int NN_DATA_W = 8;
    localparam int NN_FMAP_W = 6;
    localparam int NN_FMAP_H = 6;

    // Never returns 0, so the result can always size a vector.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [NN_DATA_W-1:0] max_u(input logic [NN_DATA_W-1:0] a,
                                                   input logic [NN_DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Stream bundle for the 2x2 max-pool stage: conv/ReLU beats in, pooled
// positions out. Drive the slave modport from the pool and the master from its peer.
interface maxpool2x2_stream_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data_0;
    logic [DATA_W-1:0] in_data_1;
    logic              out_valid;
    logic [DATA_W-1:0] out_data_0;
    logic [DATA_W-1:0] out_data_1;
    logic [IDX_W-1:0]  out_idx;
    logic              frame_done;

    modport master (
        output in_valid, in_data_0, in_data_1,
        input  out_valid, out_data_0, out_data_1, out_idx, frame_done
    );

    modport slave (
        input  in_valid, in_data_0, in_data_1,
        output out_valid, out_data_0, out_data_1, out_idx, frame_done
    );
endinterface

// File: rtl/maxpool2x2_stream_pool_lane.sv
// One channel of the 2x2 max-pool: hold register, half-width row buffer and
// the registered pooled result. Sequencing comes from the shared counters in the top.
module maxpool2x2_stream_pool_lane
    import nn_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W,
    parameter int SLOTS  = NN_FMAP_W / 2,
    parameter int SLOT_W = clog2(NN_FMAP_W / 2)
) (
    input  logic              clk,
    input  logic              flush,
    input  logic              load,
    input  logic              odd_row,
    input  logic              odd_col,
    input  logic [SLOT_W-1:0] slot,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] out_data
);

    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] rowbuf [SLOTS];

    // Hold and row buffer are always written before being read, so no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            case ({odd_row, odd_col})
                2'b00:   hold         <= in_data;
                2'b01:   rowbuf[slot] <= max_u(hold, in_data);
                2'b10:   hold         <= max_u(in_data, rowbuf[slot]);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            out_data <= '0;
        end else if (load && odd_row && odd_col) begin
            out_data <= max_u(hold, in_data);
        end
    end

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over both conv channels. Position
// counters, output index and pulses live here; the lanes carry the data.
module maxpool2x2_stream
    import nn_pkg::*;
#(
    parameter int DATA_W = NN_DATA_W,
    parameter int IN_W   = NN_FMAP_W,
    parameter int IN_H   = NN_FMAP_H
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    maxpool2x2_stream_if.slave pool
);

    localparam int OUT_N  = (IN_W / 2) * (IN_H / 2);
    localparam int IDX_W  = clog2(OUT_N);
    localparam int COL_W  = clog2(IN_W);
    localparam int ROW_W  = clog2(IN_H);
    localparam int SLOTS  = IN_W / 2;
    localparam int SLOT_W = clog2(SLOTS);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OUT_N - 1);

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [IDX_W-1:0]  idx_shown;
    logic [SLOT_W-1:0] slot;
    logic flush, beat, col_active, row_active, load, emit;

    assign flush = reset | clear;
    assign beat  = pool.in_valid & ~flush;

    // With an odd dimension the trailing column/row is counted but never pooled.
    assign col_active = (IN_W % 2 == 0) || (col != COL_LAST);
    assign row_active = (IN_H % 2 == 0) || (row != ROW_LAST);
    assign load       = beat & col_active & row_active;
    assign emit       = load & row[0] & col[0];
    assign slot       = SLOT_W'(col >> 1);

    assign idx_next  = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    assign idx_shown = pool.out_valid ? idx_next : idx;

    always_ff @(posedge clk) begin
        if (flush) begin
            col             <= '0;
            row             <= '0;
            idx             <= '0;
            pool.out_valid  <= 1'b0;
            pool.frame_done <= 1'b0;
        end else begin
            pool.out_valid  <= emit;
            pool.frame_done <= emit && (idx_shown == IDX_LAST);
            if (pool.out_valid) begin
                idx <= idx_next;
            end
            if (beat) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign pool.out_idx = idx;

    maxpool2x2_stream_pool_lane #(
        .DATA_W (DATA_W),
        .SLOTS  (SLOTS),
        .SLOT_W (SLOT_W)
    ) u_lane_0 (
        .clk      (clk),
        .flush    (flush),
        .load     (load),
        .odd_row  (row[0]),
        .odd_col  (col[0]),
        .slot     (slot),
        .in_data  (pool.in_data_0),
        .out_data (pool.out_data_0)
    );

    maxpool2x2_stream_pool_lane #(
        .DATA_W (DATA_W),
        .SLOTS  (SLOTS),
        .SLOT_W (SLOT_W)
    ) u_lane_1 (
        .clk      (clk),
        .flush    (flush),
        .load     (load),
        .odd_row  (row[0]),
        .odd_col  (col[0]),
        .slot     (slot),
        .in_data  (pool.in_data_1),
        .out_data (pool.out_data_1)
    );

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Bench for maxpool2x2_stream: a 6x6 instance and a 5x5 instance, checked
// against a window-by-window max model of each frame.
module tb_maxpool2x2_stream;
    import nn_pkg::*;

    logic clk = 1'b0;
    logic reset, clear;
    always #5 clk = ~clk;

    maxpool2x2_stream_if #(.DATA_W(8), .IDX_W(4)) bus ();
    maxpool2x2_stream_if #(.DATA_W(8), .IDX_W(2)) bus5 ();

    maxpool2x2_stream dut (.clk(clk), .reset(reset), .clear(clear), .pool(bus));
    maxpool2x2_stream #(.DATA_W(8), .IN_W(5), .IN_H(5)) dut5 (
        .clk(clk), .reset(reset), .clear(clear), .pool(bus5));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stray_fd = 0;
    int exp_idx = 0;

    logic [20:0] got_val[$];
    logic [20:0] exp_val[$];
    int          got_cyc[$];
    int          exp_cyc[$];

    int unsigned f0[36];
    int unsigned f1[36];
    int fw, fh;

    always @(posedge clk) cyc <= cyc + 1;

    // Only one instance is streamed at a time, so both feed the same queues.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            got_val.push_back({bus.frame_done, bus.out_idx, bus.out_data_1, bus.out_data_0});
            got_cyc.push_back(cyc);
        end
        if (bus5.out_valid === 1'b1) begin
            got_val.push_back({bus5.frame_done, 2'b00, bus5.out_idx, bus5.out_data_1, bus5.out_data_0});
            got_cyc.push_back(cyc);
        end
        if ((bus.frame_done === 1'b1 && bus.out_valid !== 1'b1) ||
            (bus5.frame_done === 1'b1 && bus5.out_valid !== 1'b1))
            stray_fd++;
    end

    task automatic flush_q();
        got_val.delete(); exp_val.delete(); got_cyc.delete(); exp_cyc.delete();
    endtask

    task automatic load_ramp(input int w, input int h);
        fw = w; fh = h;
        for (int i = 0; i < w * h; i++) begin
            f0[i] = i;
            f1[i] = w * h - 1 - i;
        end
    endtask

    task automatic load_const(input int unsigned v);
        fw = 6; fh = 6;
        for (int i = 0; i < 36; i++) begin
            f0[i] = v; f1[i] = v;
        end
    endtask

    function automatic int unsigned mx(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Reference: max of each 2x2 window in raster order, floor on odd sizes.
    task automatic model_frame(input int outn);
        int unsigned m0, m1;
        int p;
        logic fd;
        for (int r = 0; r < fh / 2; r++) begin
            for (int c = 0; c < fw / 2; c++) begin
                p  = 2 * r * fw + 2 * c;
                m0 = mx(mx(f0[p], f0[p + 1]), mx(f0[p + fw], f0[p + fw + 1]));
                m1 = mx(mx(f1[p], f1[p + 1]), mx(f1[p + fw], f1[p + fw + 1]));
                fd = (exp_idx == outn - 1);
                exp_val.push_back({fd, 4'(exp_idx), 8'(m1), 8'(m0)});
                exp_idx = (exp_idx + 1) % outn;
            end
        end
    endtask

    task automatic drive(input bit odd, input bit v, input int unsigned a, input int unsigned b);
        if (odd) begin
            bus5.in_valid = v; bus5.in_data_0 = 8'(a); bus5.in_data_1 = 8'(b);
        end else begin
            bus.in_valid = v; bus.in_data_0 = 8'(a); bus.in_data_1 = 8'(b);
        end
    endtask

    task automatic send_frame(input bit odd, input int max_gap, input int n_beats);
        int r, c;
        for (int i = 0; i < fw * fh && i < n_beats; i++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                @(negedge clk);
                drive(odd, 1'b0, 0, 0);
            end
            @(negedge clk);
            drive(odd, 1'b1, f0[i], f1[i]);
            r = i / fw; c = i % fw;
            if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * (fh / 2)) && (c < 2 * (fw / 2)))
                exp_cyc.push_back(cyc + 1);
        end
        @(negedge clk);
        drive(odd, 1'b0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0;
        drive(1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.frame_done, bus.out_idx, bus.out_data_0, bus.out_data_1} !== 21'd0) begin
            failures++;
            $display("FAIL reset_6x6 got=%h exp=0", {bus.out_valid, bus.frame_done, bus.out_idx, bus.out_data_0, bus.out_data_1});
        end
        checks++;
        if ({bus5.out_valid, bus5.frame_done, bus5.out_idx, bus5.out_data_0, bus5.out_data_1} !== 19'd0) begin
            failures++;
            $display("FAIL reset_5x5 got=%h exp=0", {bus5.out_valid, bus5.frame_done, bus5.out_idx, bus5.out_data_0, bus5.out_data_1});
        end
        reset = 1'b0;
        exp_idx = 0;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        flush_q();
        load_ramp(6, 6);
        model_frame(9);
        send_frame(1'b0, 0, 36);
        repeat (3) @(negedge clk);
        checks++;
        if (got_val.size() != exp_val.size()) begin
            failures++; $display("FAIL ramp_count got=%0d exp=%0d", got_val.size(), exp_val.size());
        end
        for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
            checks++;
            if (got_val[i] !== exp_val[i]) begin
                failures++; $display("FAIL ramp_out[%0d] got=%h exp=%h", i, got_val[i], exp_val[i]);
            end
            checks++;
            if (got_cyc[i] !== exp_cyc[i]) begin
                failures++; $display("FAIL ramp_cycle[%0d] got=%0d exp=%0d", i, got_cyc[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_gappy();
        flush_q();
        load_ramp(6, 6);
        model_frame(9);
        send_frame(1'b0, 5, 36);
        repeat (3) @(negedge clk);
        checks++;
        if (got_val.size() != exp_val.size()) begin
            failures++; $display("FAIL gappy_count got=%0d exp=%0d", got_val.size(), exp_val.size());
        end
        for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
            checks++;
            if (got_val[i] !== exp_val[i]) begin
                failures++; $display("FAIL gappy_out[%0d] got=%h exp=%h", i, got_val[i], exp_val[i]);
            end
            checks++;
            if (got_cyc[i] !== exp_cyc[i]) begin
                failures++; $display("FAIL gappy_cycle[%0d] got=%0d exp=%0d", i, got_cyc[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        flush_q();
        load_ramp(6, 6);
        for (int f = 0; f < 3; f++) begin
            model_frame(9);
            send_frame(1'b0, 0, 36);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (got_val.size() != 27) begin
            failures++; $display("FAIL b2b_count got=%0d exp=27", got_val.size());
        end
        for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
            checks++;
            if (got_val[i] !== exp_val[i]) begin
                failures++; $display("FAIL b2b_out[%0d] got=%h exp=%h", i, got_val[i], exp_val[i]);
            end
        end
    endtask

    task automatic test_saturation();
        flush_q();
        load_const(255); model_frame(9); send_frame(1'b0, 1, 36);
        load_const(0);   model_frame(9); send_frame(1'b0, 0, 36);
        // Single hot pixel at row 3, col 4: inside window (1,2).
        f0[22] = 255; f1[22] = 255;
        model_frame(9); send_frame(1'b0, 2, 36);
        repeat (3) @(negedge clk);
        checks++;
        if (got_val.size() != exp_val.size()) begin
            failures++; $display("FAIL sat_count got=%0d exp=%0d", got_val.size(), exp_val.size());
        end
        for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
            checks++;
            if (got_val[i] !== exp_val[i]) begin
                failures++; $display("FAIL sat_out[%0d] got=%h exp=%h", i, got_val[i], exp_val[i]);
            end
        end
    endtask

    task automatic test_reset_mid(input bit use_clear);
        load_ramp(6, 6);
        send_frame(1'b0, 0, 20);
        if (use_clear) begin
            clear = 1'b1;
            drive(1'b0, 1'b1, 99, 99);
        end else begin
            reset = 1'b1;
        end
        @(negedge clk);
        checks++;
        if ({bus.out_valid, bus.frame_done, bus.out_idx, bus.out_data_0, bus.out_data_1} !== 21'd0) begin
            failures++;
            $display("FAIL midflush_outputs clear=%0d got=%h exp=0", use_clear,
                     {bus.out_valid, bus.frame_done, bus.out_idx, bus.out_data_0, bus.out_data_1});
        end
        reset = 1'b0; clear = 1'b0;
        drive(1'b0, 1'b0, 0, 0);
        @(negedge clk);
        flush_q();
        exp_idx = 0;
        model_frame(9);
        send_frame(1'b0, 1, 36);
        repeat (3) @(negedge clk);
        checks++;
        if (got_val.size() != exp_val.size()) begin
            failures++; $display("FAIL midflush_count clear=%0d got=%0d exp=%0d", use_clear, got_val.size(), exp_val.size());
        end
        for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
            checks++;
            if (got_val[i] !== exp_val[i]) begin
                failures++; $display("FAIL midflush_out[%0d] clear=%0d got=%h exp=%h", i, use_clear, got_val[i], exp_val[i]);
            end
            checks++;
            if (got_cyc[i] !== exp_cyc[i]) begin
                failures++; $display("FAIL midflush_cycle[%0d] got=%0d exp=%0d", i, got_cyc[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_odd_dims();
        flush_q();
        exp_idx = 0;
        load_ramp(5, 5);
        model_frame(4);
        send_frame(1'b1, 2, 25);
        repeat (3) @(negedge clk);
        checks++;
        if (got_val.size() != 4) begin
            failures++; $display("FAIL odd_count got=%0d exp=4", got_val.size());
        end
        for (int i = 0; i < exp_val.size() && i < got_val.size(); i++) begin
            checks++;
            if (got_val[i] !== exp_val[i]) begin
                failures++; $display("FAIL odd_out[%0d] got=%h exp=%h", i, got_val[i], exp_val[i]);
            end
            checks++;
            if (got_cyc[i] !== exp_cyc[i]) begin
                failures++; $display("FAIL odd_cycle[%0d] got=%0d exp=%0d", i, got_cyc[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_pulses();
        checks++;
        if (stray_fd != 0) begin
            failures++; $display("FAIL stray_frame_done got=%0d exp=0", stray_fd);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_gappy();
        test_back_to_back();
        test_saturation();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_odd_dims();
        test_pulses();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
